// File: rtl/cpu_mem_responder.sv
// Arbitrates the CPU fetch and data request ports onto one downstream memory port.
// Responses are one-cycle pulses carrying registered read data.
module cpu_mem_responder #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 instruction_request,
    input  logic [WIDTH-1:0]     instruction_address,
    output logic [WIDTH-1:0]     instr,
    output logic                 instruction_response,
    input  logic                 data_request,
    input  logic                 write_enable,
    input  logic [WIDTH-1:0]     mem_address,
    input  logic [1:0]           mem_byte_enable,
    input  logic [WIDTH-1:0]     write_data,
    output logic [WIDTH-1:0]     mem_rdata,
    output logic                 data_response,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [WIDTH-1:0]     pmem_address,
    output logic [WIDTH-1:0]     pmem_wdata,
    output logic [1:0]           pmem_byte_enable,
    input  logic [WIDTH-1:0]     pmem_rdata,
    input  logic                 pmem_resp,
    input  logic                 clear_counts,
    output logic [CNT_WIDTH-1:0] conflict_count
);

    // state  | meaning
    // IDLE   | waiting for a request; arbitration happens here
    // I_BUSY | fetch transaction outstanding downstream
    // D_BUSY | load or store outstanding downstream
    // RESP   | one-cycle response pulse, no new grant
    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t               state_q, state_d;
    logic                 last_data_q, last_data_d;
    logic                 we_q, we_d;
    logic                 drop_q, drop_d;
    logic [WIDTH-1:0]     instr_q, instr_d;
    logic [WIDTH-1:0]     mem_rdata_q, mem_rdata_d;
    logic [WIDTH-1:0]     pmem_address_q, pmem_address_d;
    logic [WIDTH-1:0]     pmem_wdata_q, pmem_wdata_d;
    logic [1:0]           pmem_byte_enable_q, pmem_byte_enable_d;
    logic                 pmem_read_q, pmem_read_d;
    logic                 pmem_write_q, pmem_write_d;
    logic                 instruction_response_q, instruction_response_d;
    logic                 data_response_q, data_response_d;
    logic [CNT_WIDTH-1:0] conflict_count_q, conflict_count_d;
    logic                 grant_data, grant_instr, conflict;

    always_comb begin
        state_d                = state_q;
        last_data_d            = last_data_q;
        we_d                   = we_q;
        drop_d                 = drop_q;
        instr_d                = instr_q;
        mem_rdata_d            = mem_rdata_q;
        pmem_address_d         = pmem_address_q;
        pmem_wdata_d           = pmem_wdata_q;
        pmem_byte_enable_d     = pmem_byte_enable_q;
        pmem_read_d            = pmem_read_q;
        pmem_write_d           = pmem_write_q;
        instruction_response_d = 1'b0;
        data_response_d        = 1'b0;
        conflict               = 1'b0;
        grant_data             = 1'b0;
        grant_instr            = 1'b0;

        case (state_q)
            IDLE: begin
                conflict    = instruction_request && data_request;
                // Round-robin: on a conflict serve whichever port did not win last
                grant_data  = data_request && (!instruction_request || !last_data_q);
                grant_instr = instruction_request && !grant_data;
                if (grant_instr) begin
                    state_d            = I_BUSY;
                    pmem_address_d     = instruction_address;
                    pmem_byte_enable_d = 2'b11;
                    pmem_read_d        = 1'b1;
                    last_data_d        = 1'b0;
                    drop_d             = 1'b0;
                end else if (grant_data) begin
                    state_d            = D_BUSY;
                    pmem_address_d     = mem_address;
                    pmem_wdata_d       = write_data;
                    pmem_byte_enable_d = write_enable ? mem_byte_enable : 2'b11;
                    we_d               = write_enable;
                    pmem_read_d        = !write_enable;
                    pmem_write_d       = write_enable;
                    last_data_d        = 1'b1;
                    drop_d             = 1'b0;
                end
            end
            I_BUSY: begin
                if (pmem_resp) begin
                    pmem_read_d = 1'b0;
                    instr_d     = pmem_rdata;
                    // A flushed fetch still finishes downstream but is not acknowledged
                    if (drop_q || !instruction_request) begin
                        state_d = IDLE;
                    end else begin
                        state_d                = RESP;
                        instruction_response_d = 1'b1;
                    end
                end else begin
                    drop_d = drop_q || !instruction_request;
                end
            end
            D_BUSY: begin
                if (pmem_resp) begin
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    if (!we_q) begin
                        mem_rdata_d = pmem_rdata;
                    end
                    if (drop_q || !data_request) begin
                        state_d = IDLE;
                    end else begin
                        state_d         = RESP;
                        data_response_d = 1'b1;
                    end
                end else begin
                    drop_d = drop_q || !data_request;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clear_counts) begin
            conflict_count_d = '0;
        end else if (conflict && conflict_count_q != CNT_MAX) begin
            conflict_count_d = conflict_count_q + CNT_WIDTH'(1);
        end else begin
            conflict_count_d = conflict_count_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q                <= IDLE;
            last_data_q            <= 1'b0;
            we_q                   <= 1'b0;
            drop_q                 <= 1'b0;
            instr_q                <= '0;
            mem_rdata_q            <= '0;
            pmem_address_q         <= '0;
            pmem_wdata_q           <= '0;
            pmem_byte_enable_q     <= 2'b00;
            pmem_read_q            <= 1'b0;
            pmem_write_q           <= 1'b0;
            instruction_response_q <= 1'b0;
            data_response_q        <= 1'b0;
            conflict_count_q       <= '0;
        end else begin
            state_q                <= state_d;
            last_data_q            <= last_data_d;
            we_q                   <= we_d;
            drop_q                 <= drop_d;
            instr_q                <= instr_d;
            mem_rdata_q            <= mem_rdata_d;
            pmem_address_q         <= pmem_address_d;
            pmem_wdata_q           <= pmem_wdata_d;
            pmem_byte_enable_q     <= pmem_byte_enable_d;
            pmem_read_q            <= pmem_read_d;
            pmem_write_q           <= pmem_write_d;
            instruction_response_q <= instruction_response_d;
            data_response_q        <= data_response_d;
            conflict_count_q       <= conflict_count_d;
        end
    end

    assign instr                = instr_q;
    assign instruction_response = instruction_response_q;
    assign mem_rdata            = mem_rdata_q;
    assign data_response        = data_response_q;
    assign pmem_read            = pmem_read_q;
    assign pmem_write           = pmem_write_q;
    assign pmem_address         = pmem_address_q;
    assign pmem_wdata           = pmem_wdata_q;
    assign pmem_byte_enable     = pmem_byte_enable_q;
    assign conflict_count       = conflict_count_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder; a narrow conflict counter lets saturation be reached quickly.
module tb_cpu_mem_responder;

    localparam int WIDTH     = 16;
    localparam int CNT_WIDTH = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 instruction_request;
    logic [WIDTH-1:0]     instruction_address;
    logic [WIDTH-1:0]     instr;
    logic                 instruction_response;
    logic                 data_request;
    logic                 write_enable;
    logic [WIDTH-1:0]     mem_address;
    logic [1:0]           mem_byte_enable;
    logic [WIDTH-1:0]     write_data;
    logic [WIDTH-1:0]     mem_rdata;
    logic                 data_response;
    logic                 pmem_read;
    logic                 pmem_write;
    logic [WIDTH-1:0]     pmem_address;
    logic [WIDTH-1:0]     pmem_wdata;
    logic [1:0]           pmem_byte_enable;
    logic [WIDTH-1:0]     pmem_rdata;
    logic                 pmem_resp;
    logic                 clear_counts;
    logic [CNT_WIDTH-1:0] conflict_count;

    int checks = 0;
    int errors = 0;

    cpu_mem_responder #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk                  (clk),
        .reset                (reset),
        .instruction_request  (instruction_request),
        .instruction_address  (instruction_address),
        .instr                (instr),
        .instruction_response (instruction_response),
        .data_request         (data_request),
        .write_enable         (write_enable),
        .mem_address          (mem_address),
        .mem_byte_enable      (mem_byte_enable),
        .write_data           (write_data),
        .mem_rdata            (mem_rdata),
        .data_response        (data_response),
        .pmem_read            (pmem_read),
        .pmem_write           (pmem_write),
        .pmem_address         (pmem_address),
        .pmem_wdata           (pmem_wdata),
        .pmem_byte_enable     (pmem_byte_enable),
        .pmem_rdata           (pmem_rdata),
        .pmem_resp            (pmem_resp),
        .clear_counts         (clear_counts),
        .conflict_count       (conflict_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        instruction_request = 1'b0; instruction_address = '0;
        data_request = 1'b0; write_enable = 1'b0; mem_address = '0;
        mem_byte_enable = 2'b00; write_data = '0;
        pmem_rdata = '0; pmem_resp = 1'b0; clear_counts = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_read",  16'(pmem_read), 16'h0);
        check("rst_write", 16'(pmem_write), 16'h0);
        check("rst_iresp", 16'(instruction_response), 16'h0);
        check("rst_dresp", 16'(data_response), 16'h0);
        check("rst_instr", instr, 16'h0);
        check("rst_rdata", mem_rdata, 16'h0);
        check("rst_addr",  pmem_address, 16'h0);
        check("rst_wdata", pmem_wdata, 16'h0);
        check("rst_be",    16'(pmem_byte_enable), 16'h0);
        check("rst_cnt",   16'(conflict_count), 16'h0);
        reset = 1'b0;

        // Fetch with one-cycle memory
        instruction_request = 1'b1; instruction_address = 16'h3000;
        tick();
        check("f_read", 16'(pmem_read), 16'h1);
        check("f_write", 16'(pmem_write), 16'h0);
        check("f_addr", pmem_address, 16'h3000);
        check("f_be", 16'(pmem_byte_enable), 16'h3);
        pmem_resp = 1'b1; pmem_rdata = 16'h1234;
        tick();
        check("f_iresp", 16'(instruction_response), 16'h1);
        check("f_instr", instr, 16'h1234);
        check("f_read_off", 16'(pmem_read), 16'h0);
        check("f_dresp", 16'(data_response), 16'h0);
        pmem_resp = 1'b0; instruction_request = 1'b0;
        tick();
        check("f_pulse_end", 16'(instruction_response), 16'h0);

        // Store with three-cycle memory; inputs change mid-transaction
        data_request = 1'b1; write_enable = 1'b1; mem_address = 16'h0040;
        write_data = 16'hBEEF; mem_byte_enable = 2'b01; pmem_rdata = 16'hDEAD;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s_write", 16'(pmem_write), 16'h1);
            check("s_read", 16'(pmem_read), 16'h0);
            check("s_addr", pmem_address, 16'h0040);
            check("s_wdata", pmem_wdata, 16'hBEEF);
            check("s_be", 16'(pmem_byte_enable), 16'h1);
            mem_address = 16'h1111; write_data = 16'h2222; mem_byte_enable = 2'b10;
            if (i == 2) pmem_resp = 1'b1;
        end
        tick();
        check("s_dresp", 16'(data_response), 16'h1);
        check("s_rdata_kept", mem_rdata, 16'h0);
        check("s_write_off", 16'(pmem_write), 16'h0);
        check("s_iresp", 16'(instruction_response), 16'h0);
        pmem_resp = 1'b0; data_request = 1'b0; write_enable = 1'b0;
        tick();
        check("s_pulse_end", 16'(data_response), 16'h0);

        // Conflict from reset: data wins first
        reset = 1'b1;
        tick();
        reset = 1'b0;
        instruction_request = 1'b1; instruction_address = 16'h2000;
        data_request = 1'b1; write_enable = 1'b0; mem_address = 16'h0080;
        tick();
        check("c1_read", 16'(pmem_read), 16'h1);
        check("c1_addr", pmem_address, 16'h0080);
        check("c1_be", 16'(pmem_byte_enable), 16'h3);
        check("c1_cnt", 16'(conflict_count), 16'h1);
        pmem_resp = 1'b1; pmem_rdata = 16'h5555;
        tick();
        check("c1_dresp", 16'(data_response), 16'h1);
        check("c1_rdata", mem_rdata, 16'h5555);
        check("c1_iresp", 16'(instruction_response), 16'h0);
        pmem_resp = 1'b0; data_request = 1'b0;
        tick();
        check("c1_bubble", 16'(pmem_read), 16'h0);
        tick();
        check("c1_f_read", 16'(pmem_read), 16'h1);
        check("c1_f_addr", pmem_address, 16'h2000);
        check("c1_f_cnt", 16'(conflict_count), 16'h1);
        pmem_resp = 1'b1; pmem_rdata = 16'h6666;
        tick();
        check("c1_f_iresp", 16'(instruction_response), 16'h1);
        check("c1_f_instr", instr, 16'h6666);
        pmem_resp = 1'b0; instruction_request = 1'b0;
        tick();

        // Lone store so the last grant is data
        data_request = 1'b1; write_enable = 1'b1; mem_address = 16'h0042;
        write_data = 16'h1357; mem_byte_enable = 2'b10; pmem_resp = 1'b1;
        tick();
        check("l_write", 16'(pmem_write), 16'h1);
        check("l_be", 16'(pmem_byte_enable), 16'h2);
        tick();
        check("l_dresp", 16'(data_response), 16'h1);
        pmem_resp = 1'b0; data_request = 1'b0; write_enable = 1'b0;
        tick();

        // Second conflict: fetch wins since data went last
        instruction_request = 1'b1; instruction_address = 16'h2002;
        data_request = 1'b1; mem_address = 16'h0084;
        tick();
        check("c2_read", 16'(pmem_read), 16'h1);
        check("c2_addr", pmem_address, 16'h2002);
        check("c2_cnt", 16'(conflict_count), 16'h2);
        pmem_resp = 1'b1; pmem_rdata = 16'h2468;
        tick();
        check("c2_iresp", 16'(instruction_response), 16'h1);
        check("c2_instr", instr, 16'h2468);
        check("c2_dresp", 16'(data_response), 16'h0);
        instruction_request = 1'b0; pmem_resp = 1'b0;
        tick();
        check("c2_pulse_end", 16'(instruction_response), 16'h0);
        tick();
        check("c2_d_read", 16'(pmem_read), 16'h1);
        check("c2_d_addr", pmem_address, 16'h0084);
        check("c2_d_cnt", 16'(conflict_count), 16'h2);
        pmem_resp = 1'b1; pmem_rdata = 16'h1111;
        tick();
        check("c2_dresp2", 16'(data_response), 16'h1);
        check("c2_rdata", mem_rdata, 16'h1111);
        data_request = 1'b0; pmem_resp = 1'b0;
        tick();

        // Flushed fetch
        instruction_request = 1'b1; instruction_address = 16'h4000;
        tick();
        check("d_read", 16'(pmem_read), 16'h1);
        check("d_addr", pmem_address, 16'h4000);
        instruction_request = 1'b0;
        tick();
        check("d_read_held", 16'(pmem_read), 16'h1);
        pmem_resp = 1'b1; pmem_rdata = 16'h7777;
        tick();
        check("d_no_iresp", 16'(instruction_response), 16'h0);
        check("d_read_off", 16'(pmem_read), 16'h0);
        check("d_instr", instr, 16'h7777);
        pmem_resp = 1'b0; instruction_request = 1'b1; instruction_address = 16'h4002;
        tick();
        check("d_next_read", 16'(pmem_read), 16'h1);
        check("d_next_addr", pmem_address, 16'h4002);
        pmem_resp = 1'b1; pmem_rdata = 16'h8888;
        tick();
        check("d_next_iresp", 16'(instruction_response), 16'h1);
        check("d_next_instr", instr, 16'h8888);
        pmem_resp = 1'b0; instruction_request = 1'b0;
        tick();

        // Reset while a fetch is outstanding
        instruction_request = 1'b1; instruction_address = 16'h5000;
        tick();
        check("r_read", 16'(pmem_read), 16'h1);
        reset = 1'b1;
        #1;
        check("r_read_off", 16'(pmem_read), 16'h0);
        check("r_addr", pmem_address, 16'h0);
        check("r_instr", instr, 16'h0);
        check("r_rdata", mem_rdata, 16'h0);
        check("r_be", 16'(pmem_byte_enable), 16'h0);
        check("r_cnt", 16'(conflict_count), 16'h0);
        instruction_request = 1'b0;
        tick();
        reset = 1'b0;
        instruction_request = 1'b1; instruction_address = 16'h5002;
        tick();
        check("r_next_read", 16'(pmem_read), 16'h1);
        check("r_next_addr", pmem_address, 16'h5002);
        pmem_resp = 1'b1; pmem_rdata = 16'h9999;
        tick();
        check("r_next_iresp", 16'(instruction_response), 16'h1);
        check("r_next_instr", instr, 16'h9999);
        pmem_resp = 1'b0; instruction_request = 1'b0;
        tick();

        // Continuous conflicts with zero-wait memory: one increment every 3 cycles
        instruction_request = 1'b1; instruction_address = 16'h6000;
        data_request = 1'b1; write_enable = 1'b0; mem_address = 16'h0100;
        pmem_resp = 1'b1; pmem_rdata = 16'hABCD;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("sat_excl", 16'(instruction_response & data_response), 16'h0);
        end
        check("sat_cnt_e", 16'(conflict_count), 16'hE);
        repeat (3) tick();
        check("sat_cnt_f", 16'(conflict_count), 16'hF);
        repeat (3) tick();
        check("sat_hold", 16'(conflict_count), 16'hF);
        repeat (2) tick();
        clear_counts = 1'b1;
        tick();
        check("sat_clear", 16'(conflict_count), 16'h0);
        clear_counts = 1'b0;
        repeat (3) tick();
        check("sat_restart", 16'(conflict_count), 16'h1);
        instruction_request = 1'b0; data_request = 1'b0; pmem_resp = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
